// File: rtl/stereo_pkg.sv
// Shared geometry, width constants and offset type for the stereo offset calibrator.
package stereo_pkg;

  localparam int IMG_W_DEF  = 320;
  localparam int IMG_H_DEF  = 240;
  localparam int ROW_W_DEF  = 8;
  localparam int COL_W_DEF  = 9;
  localparam int ADDR_W_DEF = 17;
  localparam int OFS_W_DEF  = 8;

  typedef logic signed [OFS_W_DEF-1:0] ofs_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/offset_adjuster.sv
// Tick-gated saturating signed up/down counter with a synchronous-priority clear.
module offset_adjuster #(
  parameter int OFS_W = 8,
  parameter int MAX   = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick_i,
  input  logic                    up_i,
  input  logic                    down_i,
  input  logic                    clr_i,
  output logic signed [OFS_W-1:0] ofs_o
);

  localparam logic signed [OFS_W-1:0] MAX_V = OFS_W'(MAX);
  localparam logic signed [OFS_W-1:0] ONE_V = OFS_W'(1);

  logic signed [OFS_W-1:0] ofs_q, ofs_d;

  always_comb begin
    ofs_d = ofs_q;
    // Clear beats any button activity in the same cycle.
    if (clr_i) begin
      ofs_d = '0;
    end else if (tick_i && up_i && !down_i && (ofs_q < MAX_V)) begin
      ofs_d = ofs_q + ONE_V;
    end else if (tick_i && down_i && !up_i && (ofs_q > -MAX_V)) begin
      ofs_d = ofs_q - ONE_V;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ofs_q <= '0;
    else       ofs_q <= ofs_d;
  end

  assign ofs_o = ofs_q;

endmodule

// File: rtl/stereo_offset_calibrator.sv
// Left/right frame-buffer address generator with push-button calibrated right-camera offsets.
module stereo_offset_calibrator
  import stereo_pkg::*;
#(
  parameter int IMG_W          = IMG_W_DEF,
  parameter int IMG_H          = IMG_H_DEF,
  parameter int ROW_W          = ROW_W_DEF,
  parameter int COL_W          = COL_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int OFS_W          = OFS_W_DEF,
  parameter int MAX_ROW_OFS    = 15,
  parameter int MAX_COL_OFS    = 127,
  parameter int TICK_DIV       = 65536,
  parameter bit LATCH_ON_FRAME = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pix_valid_in,
  input  logic [ROW_W-1:0]  pix_row_in,
  input  logic [COL_W-1:0]  pix_col_in,
  input  logic              frame_start,
  input  logic              row_up,
  input  logic              row_down,
  input  logic              col_up,
  input  logic              col_down,
  input  logic              center,
  output logic [ADDR_W-1:0] addr_left_out,
  output logic [ADDR_W-1:0] addr_right_out,
  output logic              right_in_frame,
  output logic              pix_valid_out,
  output logic [OFS_W-1:0]  row_ofs_out,
  output logic [OFS_W-1:0]  col_ofs_out
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Wide enough that row/col plus any offset never wraps.
  localparam int CW   = max2(ROW_W, COL_W) + 2;
  localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_W);
  localparam logic signed [CW-1:0] IMG_H_S = CW'(IMG_H);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  always_comb begin
    tick = (ps_q == PS_W'(TICK_DIV - 1));
    ps_d = tick ? '0 : ps_q + PS_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ps_q <= '0;
    else     ps_q <= ps_d;
  end

  logic signed [OFS_W-1:0] row_work, col_work;
  logic signed [OFS_W-1:0] row_app, col_app;

  offset_adjuster #(.OFS_W(OFS_W), .MAX(MAX_ROW_OFS)) u_row_adj (
    .clk_i (CLK),
    .rst_i (RST),
    .tick_i(tick),
    .up_i  (row_up),
    .down_i(row_down),
    .clr_i (center),
    .ofs_o (row_work)
  );

  offset_adjuster #(.OFS_W(OFS_W), .MAX(MAX_COL_OFS)) u_col_adj (
    .clk_i (CLK),
    .rst_i (RST),
    .tick_i(tick),
    .up_i  (col_up),
    .down_i(col_down),
    .clr_i (center),
    .ofs_o (col_work)
  );

  generate
    if (LATCH_ON_FRAME) begin : g_latch
      logic signed [OFS_W-1:0] row_app_q, col_app_q;
      // Captures the pre-tick working value, so a coincident tick lands next frame.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          row_app_q <= '0;
          col_app_q <= '0;
        end else if (center) begin
          row_app_q <= '0;
          col_app_q <= '0;
        end else if (frame_start) begin
          row_app_q <= row_work;
          col_app_q <= col_work;
        end
      end
      assign row_app = row_app_q;
      assign col_app = col_app_q;
    end else begin : g_direct
      assign row_app = row_work;
      assign col_app = col_work;
    end
  endgenerate

  logic signed [CW-1:0] rr, rc;
  logic                 in_frame_d;
  logic [ADDR_W-1:0]    addr_left_d, addr_right_d;

  always_comb begin
    rr           = $signed(CW'(pix_row_in)) + CW'(row_app);
    rc           = $signed(CW'(pix_col_in)) + CW'(col_app);
    in_frame_d   = !rr[CW-1] && (rr < IMG_H_S) && !rc[CW-1] && (rc < IMG_W_S);
    addr_left_d  = ADDR_W'(pix_row_in) * ADDR_W'(IMG_W) + ADDR_W'(pix_col_in);
    addr_right_d = '0;
    if (in_frame_d) begin
      addr_right_d = ADDR_W'($unsigned(rr)) * ADDR_W'(IMG_W) + ADDR_W'($unsigned(rc));
    end
  end

  logic [ADDR_W-1:0] addr_left_q, addr_right_q;
  logic              in_frame_q, valid_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_left_q  <= '0;
      addr_right_q <= '0;
      in_frame_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      addr_left_q  <= addr_left_d;
      addr_right_q <= addr_right_d;
      in_frame_q   <= in_frame_d;
      valid_q      <= pix_valid_in;
    end
  end

  assign addr_left_out  = addr_left_q;
  assign addr_right_out = addr_right_q;
  assign right_in_frame = in_frame_q;
  assign pix_valid_out  = valid_q;
  assign row_ofs_out    = row_app;
  assign col_ofs_out    = col_app;

endmodule

// File: tb/tb_stereo_offset_calibrator.sv
// Directed test of the calibrator: latched (u_lat) and immediate (u_imm) offset variants side by side.
module tb_stereo_offset_calibrator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pix_valid_in;
  logic [7:0]  pix_row_in;
  logic [8:0]  pix_col_in;
  logic        frame_start, row_up, row_down, col_up, col_down, center;

  logic [16:0] l_addr_l, l_addr_r, i_addr_l, i_addr_r;
  logic        l_inf, l_vld, i_inf, i_vld;
  logic [7:0]  l_rofs, l_cofs, i_rofs, i_cofs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  stereo_offset_calibrator #(.TICK_DIV(4), .LATCH_ON_FRAME(1'b1)) u_lat (
    .CLK(CLK), .RST(RST), .pix_valid_in(pix_valid_in), .pix_row_in(pix_row_in),
    .pix_col_in(pix_col_in), .frame_start(frame_start), .row_up(row_up),
    .row_down(row_down), .col_up(col_up), .col_down(col_down), .center(center),
    .addr_left_out(l_addr_l), .addr_right_out(l_addr_r), .right_in_frame(l_inf),
    .pix_valid_out(l_vld), .row_ofs_out(l_rofs), .col_ofs_out(l_cofs)
  );

  stereo_offset_calibrator #(.TICK_DIV(4), .LATCH_ON_FRAME(1'b0)) u_imm (
    .CLK(CLK), .RST(RST), .pix_valid_in(pix_valid_in), .pix_row_in(pix_row_in),
    .pix_col_in(pix_col_in), .frame_start(frame_start), .row_up(row_up),
    .row_down(row_down), .col_up(col_up), .col_down(col_down), .center(center),
    .addr_left_out(i_addr_l), .addr_right_out(i_addr_r), .right_in_frame(i_inf),
    .pix_valid_out(i_vld), .row_ofs_out(i_rofs), .col_ofs_out(i_cofs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; pix_valid_in = 1'b0; pix_row_in = '0; pix_col_in = '0;
    frame_start = 1'b0; row_up = 1'b0; row_down = 1'b0;
    col_up = 1'b0; col_down = 1'b0; center = 1'b0;
    #23;
    check("rst_addr_l", 32'(l_addr_l), 0);
    check("rst_addr_r", 32'(l_addr_r), 0);
    check("rst_inf",    32'(l_inf),    0);
    check("rst_vld",    32'(l_vld),    0);
    check("rst_rofs",   32'(l_rofs),   0);
    check("rst_cofs",   32'(i_cofs),   0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Basic address generation with zero offsets.
    pix_row_in = 8'd10; pix_col_in = 9'd20; pix_valid_in = 1'b1;
    step(1);
    $display("txn basic row=10 col=20 addr_l=%0d addr_r=%0d inf=%0d", l_addr_l, l_addr_r, l_inf);
    check("basic_addr_l", 32'(l_addr_l), 3220);
    check("basic_addr_r", 32'(l_addr_r), 3220);
    check("basic_inf",    32'(l_inf),    1);
    check("basic_vld1",   32'(l_vld),    1);
    pix_valid_in = 1'b0;
    step(1);
    check("basic_vld0",   32'(l_vld),    0);

    // Twelve edges hold col_up across exactly three ticks.
    col_up = 1'b1;
    step(12);
    col_up = 1'b0;
    $display("txn col_up x3 lat_cofs=%0d imm_cofs=%0d", l_cofs, i_cofs);
    check("latch_cofs_pre", 32'(l_cofs), 0);
    check("imm_cofs_3",     32'(i_cofs), 3);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    check("latch_cofs_post", 32'(l_cofs), 3);
    step(1);
    $display("txn shifted row=10 col=20 addr_r=%0d", l_addr_r);
    check("shift_addr_r", 32'(l_addr_r), 3223);
    check("shift_inf",    32'(l_inf),    1);

    // Twenty ticks of row_down saturate at -15.
    row_down = 1'b1;
    step(80);
    row_down = 1'b0;
    check("imm_rofs_sat", 32'(i_rofs), 32'hF1);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    $display("txn row_down x20 lat_rofs=0x%0h", l_rofs);
    check("lat_rofs_sat", 32'(l_rofs), 32'hF1);
    pix_row_in = 8'd5;
    step(1);
    $display("txn row=5 shifted out addr_l=%0d addr_r=%0d inf=%0d", l_addr_l, l_addr_r, l_inf);
    check("neg_addr_l", 32'(l_addr_l), 1620);
    check("neg_inf",    32'(l_inf),    0);
    check("neg_addr_r", 32'(l_addr_r), 0);

    // Both row buttons together hold the offset.
    row_up = 1'b1; row_down = 1'b1;
    step(20);
    row_up = 1'b0; row_down = 1'b0;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    check("both_btn_hold", 32'(l_rofs), 32'hF1);

    // Center clears working and applied offsets without a frame_start.
    center = 1'b1;
    step(1);
    center = 1'b0;
    $display("txn center lat=%0d/%0d imm=%0d/%0d", l_rofs, l_cofs, i_rofs, i_cofs);
    check("ctr_lat_rofs", 32'(l_rofs), 0);
    check("ctr_lat_cofs", 32'(l_cofs), 0);
    check("ctr_imm_rofs", 32'(i_rofs), 0);
    check("ctr_imm_cofs", 32'(i_cofs), 0);

    // 140 ticks of col_up saturate at +127.
    col_up = 1'b1;
    step(560);
    col_up = 1'b0;
    $display("txn col_up x140 imm_cofs=%0d lat_cofs=%0d", i_cofs, l_cofs);
    check("imm_cofs_sat",  32'(i_cofs), 127);
    check("lat_cofs_hold", 32'(l_cofs), 0);
    pix_row_in = 8'd10; pix_col_in = 9'd200;
    step(1);
    $display("txn col=200 imm inf=%0d addr_r=%0d", i_inf, i_addr_r);
    check("c200_inf",    32'(i_inf),    0);
    check("c200_addr_r", 32'(i_addr_r), 0);
    pix_col_in = 9'd192;
    step(1);
    $display("txn col=192 imm inf=%0d addr_r=%0d", i_inf, i_addr_r);
    check("c192_inf",    32'(i_inf),    1);
    check("c192_addr_r", 32'(i_addr_r), 3519);
    pix_col_in = 9'd193;
    step(1);
    check("c193_inf",    32'(i_inf),    0);

    // Asynchronous reset during button activity.
    col_down = 1'b1;
    step(6);
    RST = 1'b1;
    #1;
    $display("txn async reset imm_cofs=%0d addr_l=%0d", i_cofs, i_addr_l);
    check("arst_cofs",   32'(i_cofs),   0);
    check("arst_addr_l", 32'(i_addr_l), 0);
    check("arst_inf",    32'(i_inf),    0);
    col_down = 1'b0;
    col_up   = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    step(3);
    check("ps_restart_pre",  32'(i_cofs), 0);
    step(1);
    check("ps_restart_tick", 32'(i_cofs), 1);
    col_up = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
